ps2_note_decoder: RTL and testbench

Converts the PS/2 keyboard scan-code byte stream (set 2, one byte per `code_valid` strobe from the PS/2 byte receiver) into the `note`/`octave`/`play` inputs that the synth control FSM and frequency lookup consume. It tracks make/break/extended prefixes, maps a 12-key piano row to note codes, and keeps a saturating octave register driven by two octave keys. Last-pressed key wins; releasing the sounding key stops the note.

---
 rtl/ps2_note_decoder.sv | 167 ++++++++++++++++
 tb/tb_ps2_note_decoder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code stream to note/octave/play decoder with prefix FSM and saturating octave.
// Optional sustain pedal input enabled by defining PS2_NOTE_DEC_SUSTAIN_EN.
module ps2_note_decoder #(
    parameter int OCT_RESET = 4,
    parameter int OCT_MAX   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic       code_valid,
`ifdef PS2_NOTE_DEC_SUSTAIN_EN
    input  logic       sustain,
`endif
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       play,
    output logic       note_change
);

    localparam logic [3:0] NOTE_NULL = 4'd15;
    localparam logic [2:0] OCT_TOP   = 3'(OCT_MAX);
    localparam logic [2:0] OCT_INIT  = 3'(OCT_RESET);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t     state, nxt_state;
    logic [7:0] code_p0;
    logic       vld_p0;
    logic       cur_held, up_held, dn_held;
    logic       nxt_cur, nxt_up, nxt_dn, nxt_play;
    logic [3:0] nxt_note;
    logic [2:0] nxt_oct;
    logic [4:0] key;
    logic       sus_on, sus_fall;

    // {hit, note} for the 12-key piano row
    function automatic logic [4:0] map_key(input logic [7:0] c);
        case (c)
            8'h33: map_key = {1'b1, 4'd0};
            8'h3C: map_key = {1'b1, 4'd1};
            8'h3B: map_key = {1'b1, 4'd2};
            8'h1C: map_key = {1'b1, 4'd3};
            8'h1D: map_key = {1'b1, 4'd4};
            8'h1B: map_key = {1'b1, 4'd5};
            8'h24: map_key = {1'b1, 4'd6};
            8'h23: map_key = {1'b1, 4'd7};
            8'h2B: map_key = {1'b1, 4'd8};
            8'h2C: map_key = {1'b1, 4'd9};
            8'h34: map_key = {1'b1, 4'd10};
            8'h35: map_key = {1'b1, 4'd11};
            default: map_key = {1'b0, NOTE_NULL};
        endcase
    endfunction

    function automatic logic [2:0] sat_step(input logic [2:0] o, input logic up);
        if (up)
            sat_step = (o >= OCT_TOP) ? OCT_TOP : o + 3'd1;
        else
            sat_step = (o == 3'd0) ? 3'd0 : o - 3'd1;
    endfunction

`ifdef PS2_NOTE_DEC_SUSTAIN_EN
    logic sustain_p0, sustain_p1;
    assign sus_on   = sustain_p0;
    assign sus_fall = sustain_p1 & ~sustain_p0;
`else
    assign sus_on   = 1'b0;
    assign sus_fall = 1'b0;
`endif

    assign key = map_key(code_p0);

    always_comb begin
        nxt_state = state;
        nxt_note  = note;
        nxt_play  = play;
        nxt_cur   = cur_held;
        nxt_up    = up_held;
        nxt_dn    = dn_held;
        nxt_oct   = octave;
        if (sus_fall && !cur_held && play) begin
            nxt_play = 1'b0;
            nxt_note = NOTE_NULL;
        end
        if (vld_p0) begin
            nxt_state = IDLE;
            case (state)
                IDLE: begin
                    if (code_p0 == 8'hE0)
                        nxt_state = EXT;
                    else if (code_p0 == 8'hF0)
                        nxt_state = BRK;
                    else if (code_p0 == 8'h22) begin
                        nxt_up = 1'b1;
                        if (!up_held) nxt_oct = sat_step(octave, 1'b1);
                    end else if (code_p0 == 8'h1A) begin
                        nxt_dn = 1'b1;
                        if (!dn_held) nxt_oct = sat_step(octave, 1'b0);
                    end else if (key[4]) begin
                        nxt_note = key[3:0];
                        nxt_play = 1'b1;
                        nxt_cur  = 1'b1;
                    end
                end
                BRK: begin
                    if (code_p0 == 8'h22)
                        nxt_up = 1'b0;
                    else if (code_p0 == 8'h1A)
                        nxt_dn = 1'b0;
                    else if (key[4] && key[3:0] == note && play) begin
                        nxt_cur = 1'b0;
                        // Pedal down keeps the note ringing until its release
                        if (!sus_on) begin
                            nxt_play = 1'b0;
                            nxt_note = NOTE_NULL;
                        end
                    end
                end
                EXT: if (code_p0 == 8'hF0) nxt_state = EXT_BRK;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // p0: input capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_p0 <= 8'h00;
            vld_p0  <= 1'b0;
`ifdef PS2_NOTE_DEC_SUSTAIN_EN
            sustain_p0 <= 1'b0;
            sustain_p1 <= 1'b0;
`endif
        end else begin
            code_p0 <= code;
            vld_p0  <= code_valid;
`ifdef PS2_NOTE_DEC_SUSTAIN_EN
            sustain_p0 <= sustain;
            sustain_p1 <= sustain_p0;
`endif
        end
    end

    // p1: decoded state and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            note        <= NOTE_NULL;
            octave      <= OCT_INIT;
            play        <= 1'b0;
            note_change <= 1'b0;
            cur_held    <= 1'b0;
            up_held     <= 1'b0;
            dn_held     <= 1'b0;
        end else begin
            state       <= nxt_state;
            note        <= nxt_note;
            octave      <= nxt_oct;
            play        <= nxt_play;
            note_change <= (nxt_note != note) || (nxt_play != play);
            cur_held    <= nxt_cur;
            up_held     <= nxt_up;
            dn_held     <= nxt_dn;
        end
    end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder; sustain tests run when PS2_NOTE_DEC_SUSTAIN_EN is defined.
module tb_ps2_note_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code;
    logic       code_valid;
    logic       sustain;
    logic [3:0] note;
    logic [2:0] octave;
    logic       play;
    logic       note_change;

    int checks = 0;
    int errors = 0;

    ps2_note_decoder #(.OCT_RESET(4), .OCT_MAX(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .code        (code),
        .code_valid  (code_valid),
`ifdef PS2_NOTE_DEC_SUSTAIN_EN
        .sustain     (sustain),
`endif
        .note        (note),
        .octave      (octave),
        .play        (play),
        .note_change (note_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        code       = b;
        code_valid = 1'b1;
    endtask

    // Drop valid, then wait until the last byte's output update is visible
    task automatic settle();
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic [3:0] n, input logic [2:0] o,
                        input logic p, input logic nc);
        chk({tag, ".note"}, 8'(note), 8'(n));
        chk({tag, ".octave"}, 8'(octave), 8'(o));
        chk({tag, ".play"}, 8'(play), 8'(p));
        chk({tag, ".note_change"}, 8'(note_change), 8'(nc));
    endtask

    initial begin
        reset = 1'b1; code = 8'h00; code_valid = 1'b0; sustain = 1'b0;
        repeat (3) @(negedge clk);
        outs("reset", 4'd15, 3'd4, 1'b0, 1'b0);
        reset = 1'b0;

        // first make, with latency check
        put(8'h1C);
        @(negedge clk);
        code_valid = 1'b0;
        chk("latency.play", 8'(play), 8'd0);
        @(negedge clk);
        outs("make_1c", 4'd3, 3'd4, 1'b1, 1'b1);
        @(negedge clk);
        chk("pulse_one_cycle", 8'(note_change), 8'd0);

        put(8'h33); settle();
        outs("make_33", 4'd0, 3'd4, 1'b1, 1'b1);
        put(8'hF0); put(8'h1C); settle();
        outs("brk_other", 4'd0, 3'd4, 1'b1, 1'b0);
        put(8'h33); settle();
        outs("typematic", 4'd0, 3'd4, 1'b1, 1'b0);
        put(8'hF0); put(8'h33); settle();
        outs("brk_cur", 4'd15, 3'd4, 1'b0, 1'b1);

        // octave keys
        put(8'h22); put(8'h22); put(8'h22); settle();
        outs("oct_up_held", 4'd15, 3'd5, 1'b0, 1'b0);
        repeat (2) begin put(8'hF0); put(8'h22); put(8'h22); end
        settle();
        chk("oct_up_sat", 8'(octave), 8'd6);
        put(8'hF0); put(8'h22); put(8'h22); settle();
        chk("oct_up_sat2", 8'(octave), 8'd6);
        put(8'h2B); settle();
        outs("note_at_oct6", 4'd8, 3'd6, 1'b1, 1'b1);
        repeat (7) begin put(8'h1A); put(8'hF0); put(8'h1A); end
        settle();
        outs("oct_down_sat", 4'd8, 3'd0, 1'b1, 1'b0);

        // extended and unmapped codes
        put(8'h1C); settle();
        outs("make_1c_b", 4'd3, 3'd0, 1'b1, 1'b1);
        put(8'hE0); put(8'h1D); settle();
        outs("ext_make", 4'd3, 3'd0, 1'b1, 1'b0);
        put(8'hE0); put(8'hF0); put(8'h1C); settle();
        outs("ext_brk", 4'd3, 3'd0, 1'b1, 1'b0);
        put(8'h15); put(8'hF0); put(8'h15); settle();
        outs("unmapped", 4'd3, 3'd0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        outs("hold_idle", 4'd3, 3'd0, 1'b1, 1'b0);

        // reset between F0 and 1C discards the prefix
        put(8'hF0); settle();
        #2 reset = 1'b1;
        #1 outs("async_reset", 4'd15, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        put(8'h1C); settle();
        outs("post_reset_make", 4'd3, 3'd4, 1'b1, 1'b1);

`ifdef PS2_NOTE_DEC_SUSTAIN_EN
        put(8'hF0); put(8'h1C); settle();
        sustain = 1'b1;
        put(8'h1C); put(8'hF0); put(8'h1C); settle();
        outs("sus_hold", 4'd3, 3'd4, 1'b1, 1'b0);
        @(negedge clk);
        sustain = 1'b0;
        @(negedge clk);
        @(negedge clk);
        outs("sus_release", 4'd15, 3'd4, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
